// File: rtl/uart_tx_framer.sv
// Burst UART transmitter: loads word_number 32-bit words, then sends them as 8N1 frames, low byte first.
// Latency: first start bit in the first SEND cycle; each frame lasts 10*DIV_RATE clocks; done pulses one cycle after the last stop bit.
// Backpressure: uart_slave_read_ready is high only in LOAD; valid gaps stall loading, and start is ignored while busy.
module uart_tx_framer #(
    parameter int DIV_RATE  = 16,
    parameter int MAX_WORDS = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [2:0]  word_number,
    input  logic        start,
    output logic        uart_slave_read_ready,
    input  logic [31:0] uart_slave_data,
    input  logic        uart_slave_data_valid,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int BYTES = 4 * MAX_WORDS;
    localparam int IW    = $clog2(BYTES);
    localparam int LW    = $clog2(BYTES + 1);
    localparam int DW    = $clog2(DIV_RATE);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV_RATE - 1);
    localparam logic [3:0]    MAX_WN   = 4'(MAX_WORDS);

    typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;

    state_t          state, state_nxt;
    logic [LW-1:0]   byte_limit;
    logic [LW-1:0]   wr_idx;
    logic [LW-1:0]   wr_idx_nxt;
    logic [IW-1:0]   tx_idx;
    logic [DW-1:0]   div_cnt;
    logic [3:0]      bit_cnt;
    logic [7:0]      byte_buf [BYTES];
    logic [7:0]      cur_byte;
    logic [2:0]      data_sel;
    logic            start_ok;
    logic            word_acc;
    logic            bit_end;
    logic            frame_end;
    logic            last_byte;

    assign start_ok   = start && (word_number != 3'd0) && ({1'b0, word_number} <= MAX_WN);
    assign word_acc   = (state == LOAD) && uart_slave_data_valid;
    assign wr_idx_nxt = wr_idx + LW'(4);
    assign bit_end    = (div_cnt == DIV_LAST);
    assign frame_end  = bit_end && (bit_cnt == 4'd9);
    assign last_byte  = ((LW'(tx_idx) + LW'(1)) == byte_limit);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start_ok) state_nxt = LOAD;
            LOAD: if (word_acc && (wr_idx_nxt == byte_limit)) state_nxt = SEND;
            SEND: if (frame_end && last_byte) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            byte_limit <= '0;
            wr_idx     <= '0;
            tx_idx     <= '0;
            div_cnt    <= '0;
            bit_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        byte_limit <= LW'({word_number, 2'b00});
                        wr_idx     <= '0;
                        tx_idx     <= '0;
                        div_cnt    <= '0;
                        bit_cnt    <= '0;
                    end
                end
                LOAD: begin
                    if (word_acc) wr_idx <= wr_idx_nxt;
                end
                SEND: begin
                    if (bit_end) begin
                        div_cnt <= '0;
                        if (bit_cnt == 4'd9) begin
                            bit_cnt <= '0;
                            // Holding tx_idx on the last byte keeps it inside the buffer.
                            if (!last_byte) tx_idx <= tx_idx + IW'(1);
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Buffer contents are don't-care after reset, so it carries no reset.
    always_ff @(posedge clk) begin
        if (word_acc) begin
            for (int k = 0; k < 4; k++) begin
                byte_buf[wr_idx[IW-1:0] + IW'(k)] <= uart_slave_data[8*k +: 8];
            end
        end
    end

    assign cur_byte = byte_buf[tx_idx];
    assign data_sel = 3'(bit_cnt - 4'd1);

    always_comb begin
        tx = 1'b1;
        if (state == SEND) begin
            case (bit_cnt)
                4'd0:    tx = 1'b0;
                4'd9:    tx = 1'b1;
                default: tx = cur_byte[data_sel];
            endcase
        end
    end

    assign busy                  = (state != IDLE);
    assign done                  = (state == DONE);
    assign uart_slave_read_ready = (state == LOAD);

endmodule

// File: doc/uart_tx_framer.md
UART_TX_FRAMER -- requirements
Module: uart_tx_framer

Interface
REQ-001 Parameter DIV_RATE, default 16, clocks per serial bit (SHALL be >= 2).
REQ-002 Parameter MAX_WORDS, default 4, byte-buffer capacity in 32-bit words (buffer = 4*MAX_WORDS bytes).
REQ-003 Port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port resetn  input  1  asynchronous, active-low reset.
REQ-005 Port word_number  input  3  number of 32-bit words in the burst; sampled only on an accepted start.
REQ-006 Port start  input  1  single-cycle burst request from the UART controller.
REQ-007 Port uart_slave_read_ready  output  1  high while the block accepts words from the bus.
REQ-008 Port uart_slave_data  input  32  word from the bus; consumed only when valid and ready are both high.
REQ-009 Port uart_slave_data_valid  input  1  qualifies uart_slave_data.
REQ-010 Port tx  output  1  serial line; idle level high.
REQ-011 Port busy  output  1  high in every state except IDLE.
REQ-012 Port done  output  1  single-cycle pulse at burst completion.

Function
REQ-013 FSM states: IDLE, LOAD, SEND, DONE.
REQ-014 IDLE: start=1 with 1 <= word_number <= MAX_WORDS SHALL latch byte_limit = word_number*4, clear write index, and enter LOAD next cycle.
REQ-015 IDLE: start with word_number = 0 or > MAX_WORDS SHALL be ignored; FSM stays in IDLE and done stays low.
REQ-016 LOAD: uart_slave_read_ready SHALL be high; each cycle with valid=1 SHALL store the word little-endian: buf[i]=data[7:0], buf[i+1]=data[15:8], buf[i+2]=data[23:16], buf[i+3]=data[31:24], then i += 4.
REQ-017 LOAD: when the accepted word makes i reach byte_limit, ready SHALL drop in the next cycle, no further words are accepted, and the FSM enters SEND.
REQ-018 valid while ready is low SHALL be ignored; valid gaps in LOAD SHALL stall loading without error.
REQ-019 SEND: bytes SHALL go out in buffer order, index 0 first; each frame = start bit 0, data bits 0..7 LSB first, stop bit 1.
REQ-020 Each bit SHALL hold tx for exactly DIV_RATE clocks; a frame SHALL last 10*DIV_RATE clocks; consecutive frames SHALL be back-to-back with no idle gap.
REQ-021 The first start bit SHALL appear on tx in the first cycle of SEND.
REQ-022 After the stop bit of byte byte_limit-1 completes, the FSM SHALL enter DONE, assert done for exactly one cycle, then return to IDLE.
REQ-023 tx SHALL be high in IDLE, LOAD and DONE.
REQ-024 start asserted while busy=1 SHALL be ignored and SHALL NOT alter word_number, the buffer or the timing.
REQ-025 Bit-period counter and bit counter SHALL be sized so that DIV_RATE and 10 bits per frame never wrap mid-frame; the byte index SHALL never exceed 4*MAX_WORDS-1.
REQ-026 Total burst latency, start to done = (word_number*4*10*DIV_RATE) + (load cycles) + 2 clocks, where load cycles = cycles spent in LOAD.

Reset
REQ-027 resetn low SHALL immediately force state=IDLE, tx=1, busy=0, done=0, uart_slave_read_ready=0, and clear all counters and indices.
REQ-028 Reset asserted mid-LOAD or mid-frame SHALL abort the burst; after release, the block SHALL accept a fresh start normally; buffer contents are don't-care.

Verification
REQ-029 word_number=1, start, word 0x44332211 valid at once, DIV_RATE=16 -> bytes 0x11,0x22,0x33,0x44 on tx, LSB first, each 160 clocks, one done pulse.
REQ-030 word_number=4, valid toggled 1/0 every cycle -> exactly 4 words accepted, ready low after the 4th, 16 frames back-to-back, byte order matches little-endian.
REQ-031 start with word_number=0, then with 5 -> busy stays 0, tx stays 1, ready stays 0, no done.
REQ-032 start pulsed again during SEND with word_number=2 -> ignored; original frame count and timing unchanged.
REQ-033 resetn low in the middle of the data bit 3 of byte 1 -> tx=1 and busy=0 asynchronously; a new 1-word burst after release transmits correctly.
REQ-034 Checker: every bit period is exactly DIV_RATE clocks; stop bit = 1; tx never low outside SEND.
